// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline hazard controller.
package pipeline_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} HazardState_t;
    typedef struct packed {
        logic stall;
        logic flush;
    } PipeCtrl_t;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: wrapping enable counter with synchronous reset.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_o <= '0;
        else if (en_i) cnt_o <= cnt_o + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: fixed-priority stall/flush controller for the five-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             id_serialize_i,
    input  logic             id_valid_i,
    input  logic             ex_valid_i,
    input  logic             mem_valid_i,
    input  logic             wb_valid_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             imem_busy_i,
    input  logic             dmem_busy_i,
    output logic             pc_stall_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_flush_o,
    output logic             exmem_stall_o,
    output logic             exmem_flush_o,
    output logic             memwb_stall_o,
    output logic             memwb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    HazardState_t state, state_n;
    logic [2:0] bub, bub_n;
    logic [XLEN-1:0] pc_shadow;
    PipeCtrl_t ifid, idex, exmem, memwb;
    logic down_valid, ser_haz, load_use;

    assign down_valid = ex_valid_i | mem_valid_i | wb_valid_i;
    assign ser_haz = id_valid_i & id_serialize_i & down_valid;
    assign load_use = ex_valid_i & ex_is_load_i & (ex_rd_i != REG_X0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        ifid = '0;
        idex = '0;
        exmem = '0;
        memwb = '0;
        pc_stall_o = 1'b0;
        redirect_valid_o = 1'b0;
        state_n = state;
        bub_n = bub;
        if (rst_i) begin
            ifid.flush = 1'b1;
            idex.flush = 1'b1;
            exmem.flush = 1'b1;
            memwb.flush = 1'b1;
            state_n = RUN;
            bub_n = '0;
        end else if (dmem_busy_i) begin
            // Whole pipe frozen; a pending redirect re-presents from the held EX stage.
            pc_stall_o = 1'b1;
            ifid.stall = 1'b1;
            idex.stall = 1'b1;
            exmem.stall = 1'b1;
            memwb.flush = 1'b1;
        end else if (ex_redirect_i) begin
            redirect_valid_o = 1'b1;
            ifid.flush = 1'b1;
            idex.flush = 1'b1;
            state_n = REDIRECT;
            bub_n = 3'(REDIRECT_BUBBLES);
        end else if (state == REDIRECT) begin
            ifid.flush = 1'b1;
            bub_n = bub - 1'b1;
            state_n = (bub == 3'd1) ? RUN : REDIRECT;
        end else if (ser_haz || (state == DRAIN && down_valid)) begin
            pc_stall_o = 1'b1;
            ifid.stall = 1'b1;
            idex.flush = 1'b1;
            state_n = DRAIN;
        end else begin
            state_n = RUN;
            if (load_use) begin
                pc_stall_o = 1'b1;
                ifid.stall = 1'b1;
                idex.flush = 1'b1;
            end else if (imem_busy_i) begin
                pc_stall_o = 1'b1;
                ifid.flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            bub <= '0;
            pc_shadow <= '0;
        end else begin
            state <= state_n;
            bub <= bub_n;
            if (redirect_valid_o) pc_shadow <= ex_target_i;
        end
    end

    assign redirect_pc_o = redirect_valid_o ? ex_target_i : pc_shadow;
    assign ifid_stall_o = ifid.stall;
    assign ifid_flush_o = ifid.flush;
    assign idex_stall_o = idex.stall;
    assign idex_flush_o = idex.flush;
    assign exmem_stall_o = exmem.stall;
    assign exmem_flush_o = exmem.flush;
    assign memwb_stall_o = memwb.stall;
    assign memwb_flush_o = memwb.flush;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(pc_stall_o), .cnt_o(stall_cnt_o)
    );
    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(ifid_flush_o), .cnt_o(flush_cnt_o)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors checked through an expected-response queue.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b1;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, id_serialize, id_valid, ex_valid, mem_valid, wb_valid;
    logic ex_is_load, ex_redirect, imem_busy, dmem_busy;
    logic [63:0] ex_target, redirect_pc;
    logic pc_stall, redirect_valid;
    logic ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_stall, memwb_flush;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        int          id;
        logic [8:0]  ctrl;
        logic        rv;
        logic [63:0] pc;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, step_id = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.XLEN(64), .REDIRECT_BUBBLES(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_serialize_i(id_serialize), .id_valid_i(id_valid),
        .ex_valid_i(ex_valid), .mem_valid_i(mem_valid), .wb_valid_i(wb_valid),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
        .imem_busy_i(imem_busy), .dmem_busy_i(dmem_busy),
        .pc_stall_o(pc_stall), .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
        .idex_stall_o(idex_stall), .idex_flush_o(idex_flush),
        .exmem_stall_o(exmem_stall), .exmem_flush_o(exmem_flush),
        .memwb_stall_o(memwb_stall), .memwb_flush_o(memwb_flush),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // ctrl bit order: pc_stall, ifid s/f, idex s/f, exmem s/f, memwb s/f
    localparam logic [8:0] NONE   = 9'b000000000;
    localparam logic [8:0] RSTF   = 9'b001010101;
    localparam logic [8:0] HOLD   = 9'b110010000;
    localparam logic [8:0] REDIR  = 9'b001010000;
    localparam logic [8:0] BUBBLE = 9'b001000000;
    localparam logic [8:0] FREEZE = 9'b110101001;
    localparam logic [8:0] IMISS  = 9'b101000000;

    task automatic clr();
        rst = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_serialize = 0; id_valid = 0; ex_valid = 0; mem_valid = 0; wb_valid = 0;
        ex_is_load = 0; ex_redirect = 0; ex_target = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic chk(input logic [8:0] c, input logic rv, input logic [63:0] pc,
                       input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        step_id++;
        e.id = step_id; e.ctrl = c; e.rv = rv; e.pc = pc; e.sc = sc; e.fc = fc;
        q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [8:0] act;
            e = q.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_stall, exmem_flush, memwb_stall, memwb_flush};
            tests += 5;
            if (act !== e.ctrl) begin
                fails++; $display("FAIL step%0d ctrl: got %b want %b", e.id, act, e.ctrl);
            end
            if (redirect_valid !== e.rv) begin
                fails++; $display("FAIL step%0d redirect_valid: got %b want %b", e.id, redirect_valid, e.rv);
            end
            if (redirect_pc !== e.pc) begin
                fails++; $display("FAIL step%0d redirect_pc: got %h want %h", e.id, redirect_pc, e.pc);
            end
            if (stall_cnt !== e.sc) begin
                fails++; $display("FAIL step%0d stall_cnt: got %0d want %0d", e.id, stall_cnt, e.sc);
            end
            if (flush_cnt !== e.fc) begin
                fails++; $display("FAIL step%0d flush_cnt: got %0d want %0d", e.id, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        clr();
        rst = 1; chk(RSTF, 0, 0, 0, 0);
        rst = 1; chk(RSTF, 0, 0, 0, 0);
        chk(NONE, 0, 0, 0, 0);
        // load-use on rs1, then rd==x0, then rs2 with and without use
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; chk(HOLD, 0, 0, 0, 0);
        chk(NONE, 0, 0, 1, 0);
        ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0; chk(NONE, 0, 0, 1, 0);
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7; chk(HOLD, 0, 0, 1, 0);
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; chk(NONE, 0, 0, 2, 0);
        // redirect with two trailing bubbles
        ex_redirect = 1; ex_target = 64'h8000_0040; chk(REDIR, 1, 64'h8000_0040, 2, 0);
        chk(BUBBLE, 0, 64'h8000_0040, 2, 1);
        chk(BUBBLE, 0, 64'h8000_0040, 2, 2);
        chk(NONE, 0, 64'h8000_0040, 2, 3);
        // data-memory freeze holds off a pending redirect
        for (int i = 0; i < 3; i++) begin
            dmem_busy = 1; ex_redirect = 1; ex_target = 64'h1234;
            chk(FREEZE, 0, 64'h8000_0040, 32'(2 + i), 3);
        end
        ex_redirect = 1; ex_target = 64'h1234; chk(REDIR, 1, 64'h1234, 5, 3);
        chk(BUBBLE, 0, 64'h1234, 5, 4);
        chk(BUBBLE, 0, 64'h1234, 5, 5);
        chk(NONE, 0, 64'h1234, 5, 6);
        // serialize drain, released once downstream is empty
        id_serialize = 1; id_valid = 1; mem_valid = 1; wb_valid = 1; chk(HOLD, 0, 64'h1234, 5, 6);
        id_serialize = 1; id_valid = 1; mem_valid = 1; wb_valid = 1; chk(HOLD, 0, 64'h1234, 6, 6);
        chk(NONE, 0, 64'h1234, 7, 6);
        chk(NONE, 0, 64'h1234, 7, 6);
        // DRAIN persists on downstream valid alone, then a redirect overrides it
        id_serialize = 1; id_valid = 1; ex_valid = 1; chk(HOLD, 0, 64'h1234, 7, 6);
        ex_valid = 1; chk(HOLD, 0, 64'h1234, 8, 6);
        ex_valid = 1; ex_redirect = 1; ex_target = 64'h40; chk(REDIR, 1, 64'h40, 9, 6);
        // reset with one bubble left: no residual flush afterwards
        chk(BUBBLE, 0, 64'h40, 9, 7);
        rst = 1; chk(RSTF, 0, 64'h40, 9, 8);
        chk(NONE, 0, 0, 0, 0);
        // instruction-memory miss inserts a fetch bubble
        imem_busy = 1; chk(IMISS, 0, 0, 0, 0);
        chk(NONE, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++; $display("FAIL queue_drain: got %0d left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage RV64I pipeline.
- Drives stall_i/flush_i of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC enable and redirect.
- Resolves, by fixed priority: data-memory wait, EX-stage branch/jump redirect, serializing-instruction drain, load-use hazard, instruction-memory wait.
- Keeps stall and flush performance counters.

Parameters:
- XLEN, 64, PC width.
- REDIRECT_BUBBLES, 1, cycles IF/ID is squashed after a redirect to kill stale fetches (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- id_rs1_i in 5: ID source register 1.
- id_rs2_i in 5: ID source register 2.
- id_use_rs1_i in 1: ID instruction reads rs1.
- id_use_rs2_i in 1: ID instruction reads rs2.
- id_serialize_i in 1: ID holds fence/fence.i/ecall/ebreak/csr.
- id_valid_i in 1: ID holds a valid instruction.
- ex_valid_i in 1: EX stage valid.
- mem_valid_i in 1: MEM stage valid.
- wb_valid_i in 1: WB stage valid.
- ex_is_load_i in 1: EX instruction is a load.
- ex_rd_i in 5: EX destination register.
- ex_redirect_i in 1: EX resolved a taken branch, jump or mispredict.
- ex_target_i in XLEN: redirect target.
- imem_busy_i in 1: fetch data not ready.
- dmem_busy_i in 1: data memory access not complete.
- pc_stall_o out 1: hold PC.
- redirect_valid_o out 1: load PC from redirect_pc_o.
- redirect_pc_o out XLEN: redirect target.
- ifid_stall_o, ifid_flush_o out 1 each: IF/ID register control.
- idex_stall_o, idex_flush_o out 1 each: ID/EX register control.
- exmem_stall_o, exmem_flush_o out 1 each: EX/MEM register control.
- memwb_stall_o, memwb_flush_o out 1 each: MEM/WB register control.
- stall_cnt_o out CNT_W: cycles with pc_stall_o=1.
- flush_cnt_o out CNT_W: cycles with ifid_flush_o=1.

Behaviour:
- Control outputs are combinational from inputs and registered state; the pipeline registers sample them at the same edge.
- FSM state, bubble counter and performance counters are registered.
- A stage never sees stall and flush asserted together; flush wins.
- Reset (rst_i=1, sampled at posedge):
  - State goes to RUN; bubble counter and both perf counters go to 0.
  - While rst_i is high: all *_flush_o=1, all *_stall_o=0, redirect_valid_o=0, pc_stall_o=0.
  - Reset mid-DRAIN or mid-REDIRECT abandons that state with no residual effect.
- FSM states: RUN, DRAIN, REDIRECT. Priority per cycle, highest first:
  1. dmem_busy_i: freeze. pc, ifid, idex and exmem stall; memwb_flush=1 (WB gets a bubble, no duplicate writeback). redirect_valid_o=0, because the branch is held in frozen EX and re-presents. State and bubble counter hold.
  2. ex_redirect_i:
     - redirect_valid_o=1, redirect_pc_o=ex_target_i.
     - ifid_flush=1, idex_flush=1; pc not stalled.
     - Next state REDIRECT with bubble counter=REDIRECT_BUBBLES.
     - Overrides DRAIN, load-use and an in-progress REDIRECT (counter reloads).
  3. state==REDIRECT:
     - ifid_flush=1; counter decrements.
     - Return to RUN when the counter reaches 0 after the decrement.
     - The fetch is not stalled.
  4. Serialize hazard: id_valid_i & id_serialize_i & (ex_valid_i|mem_valid_i|wb_valid_i).
     - pc_stall=1, ifid_stall=1, idex_flush=1.
     - State goes to DRAIN and stays there while any downstream stage is valid.
     - In DRAIN with all stages empty: release (no stall) in that same cycle and return to RUN.
  5. Load-use: ex_valid_i & ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
     - pc_stall=1, ifid_stall=1, idex_flush=1 for exactly the one cycle the hazard holds.
     - No rd==x0 hazard.
  6. imem_busy_i: pc_stall=1, ifid_flush=1 (bubble into ID); downstream proceeds.
- Default: all stalls/flushes 0.
- redirect_pc_o: equals ex_target_i whenever redirect_valid_o=1; holds its last value otherwise (registered shadow, reset 0).
- Counters: increment by 1 per qualifying cycle and wrap at 2^CNT_W. They do not count during reset.

Decomposition:
- pipeline_pkg gains:
  - HazardState_t enum {RUN, DRAIN, REDIRECT}.
  - PipeCtrl_t struct {stall, flush}.
  - constant REG_X0 = 5'd0.
- One natural sub-module: hazard_perf_counter (a CNT_W enable counter with synchronous reset), instantiated twice.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_use_rs1=1, id_rs1=5, one cycle -> pc_stall=ifid_stall=idex_flush=1 for that cycle only, stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- Redirect, REDIRECT_BUBBLES=2: ex_redirect=1, target=64'h8000_0040 -> redirect_valid=1, redirect_pc=64'h8000_0040, ifid_flush=idex_flush=1; then ifid_flush=1 for exactly 2 more cycles, then RUN; flush_cnt=3.
- Freeze precedence: dmem_busy=1 for 3 cycles together with ex_redirect=1 -> redirect_valid=0, memwb_flush=1, pc/ifid/idex/exmem stall=1 each cycle; on cycle 4 (busy=0) the redirect fires.
- Drain: id_serialize=1, id_valid=1, mem_valid=1, wb_valid=1 for 2 cycles, then all 0 -> state DRAIN with pc_stall=1 for 2 cycles; on the third cycle no stall and state RUN.
- Redirect during DRAIN: ex_redirect asserted in DRAIN -> idex_flush=ifid_flush=1, state REDIRECT, no pc_stall that cycle.
- Reset mid-REDIRECT: rst_i=1 one cycle at bubble count 1 -> all flushes=1 that cycle; state RUN, stall_cnt=flush_cnt=0 afterwards; no residual ifid_flush.
